// File: rtl/pointing_device_decoder.sv
// Decodes a three-byte pointing-device packet stream and two device-ID bytes.
// It tracks a clamped absolute cursor and counts framing errors.
module pointing_device_decoder #(
  parameter int kTimeoutCycles = 600000,
  parameter int kMaxX = 767,
  parameter int kMaxY = 559
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rts,
  input  logic [7:0] serial_in_data,
  input  logic       serial_in_write,
  output logic       packet_valid,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       b1,
  output logic       b2,
  output logic       id_valid,
  output logic       device_type,
  output logic       device_known,
  output logic [9:0] cursor_x,
  output logic [9:0] cursor_y,
  output logic       err,
  output logic [7:0] err_count
);

  localparam int kCntW = $clog2(kTimeoutCycles + 1);
  localparam logic [kCntW-1:0] kCntLast = kCntW'(kTimeoutCycles - 1);
  localparam logic signed [10:0] kLimX = 11'(kMaxX);
  localparam logic signed [10:0] kLimY = 11'(kMaxY);

  typedef enum logic [1:0] {EMPTY, HEAD, GOT_X} state_t;

  state_t           state_reg, state_next;
  logic [7:0]       pending_reg, pending_next;
  logic [5:0]       xlow_reg, xlow_next;
  logic [kCntW-1:0] count_reg, count_next;
  logic [7:0]       x_reg, x_next, y_reg, y_next;
  logic             b1_reg, b1_next, b2_reg, b2_next;
  logic             packet_valid_reg, packet_valid_next;
  logic             id_valid_reg, id_valid_next;
  logic             err_reg, err_next;
  logic             device_type_reg, device_type_next;
  logic             device_known_reg, device_known_next;
  logic [9:0]       cursor_x_reg, cursor_x_next, cursor_y_reg, cursor_y_next;
  logic [7:0]       err_count_reg, err_count_next;
  logic             resolve_id;
  logic             is_head, is_body, timeout_hit;
  logic [7:0]       pkt_x, pkt_y;

  assign is_head     = (serial_in_data[7:6] == 2'b11);
  assign is_body     = (serial_in_data[7:6] == 2'b10);
  assign timeout_hit = (state_reg != EMPTY) && (count_reg == kCntLast);
  assign pkt_x       = {pending_reg[1:0], xlow_reg};
  assign pkt_y       = {pending_reg[3:2], serial_in_data[5:0]};

  // Sum is formed at 11-bit signed width so negative results clamp to zero.
  function automatic logic [9:0] clamp_add(input logic [9:0] pos, input logic [7:0] delta,
                                           input logic signed [10:0] lim);
    logic signed [10:0] sum;
    sum = $signed({1'b0, pos}) + $signed({{3{delta[7]}}, delta});
    if (sum < 11'sd0)     clamp_add = '0;
    else if (sum > lim)   clamp_add = lim[9:0];
    else                  clamp_add = sum[9:0];
  endfunction

  always_comb begin
    state_next        = state_reg;
    pending_next      = pending_reg;
    xlow_next         = xlow_reg;
    count_next        = count_reg;
    x_next            = x_reg;
    y_next            = y_reg;
    b1_next           = b1_reg;
    b2_next           = b2_reg;
    packet_valid_next = 1'b0;
    id_valid_next     = 1'b0;
    err_next          = 1'b0;
    device_type_next  = device_type_reg;
    device_known_next = device_known_reg;
    cursor_x_next     = cursor_x_reg;
    cursor_y_next     = cursor_y_reg;
    err_count_next    = err_count_reg;
    resolve_id        = 1'b0;

    if (rts) begin
      state_next        = EMPTY;
      pending_next      = '0;
      count_next        = '0;
      device_known_next = 1'b0;
    end else if (serial_in_write) begin
      count_next = '0;
      case (state_reg)
        EMPTY: begin
          if (is_head) begin
            pending_next = serial_in_data;
            state_next   = HEAD;
          end else begin
            err_next = 1'b1;
          end
        end
        HEAD: begin
          if (is_body) begin
            xlow_next  = serial_in_data[5:0];
            state_next = GOT_X;
          end else if (is_head) begin
            resolve_id   = 1'b1;
            pending_next = serial_in_data;
          end else begin
            err_next   = 1'b1;
            state_next = EMPTY;
          end
        end
        GOT_X: begin
          if (is_body) begin
            x_next            = pkt_x;
            y_next            = pkt_y;
            b1_next           = pending_reg[5];
            b2_next           = pending_reg[4];
            cursor_x_next     = clamp_add(cursor_x_reg, pkt_x, kLimX);
            cursor_y_next     = clamp_add(cursor_y_reg, pkt_y, kLimY);
            packet_valid_next = 1'b1;
            state_next        = EMPTY;
          end else if (is_head) begin
            err_next     = 1'b1;
            pending_next = serial_in_data;
            state_next   = HEAD;
          end else begin
            err_next   = 1'b1;
            state_next = EMPTY;
          end
        end
        default: state_next = EMPTY;
      endcase
    end else if (timeout_hit) begin
      count_next = '0;
      state_next = EMPTY;
      if (state_reg == HEAD) resolve_id = 1'b1;
      else                   err_next   = 1'b1;
    end else if (state_reg != EMPTY) begin
      count_next = count_reg + kCntW'(1);
    end

    if (resolve_id) begin
      if (pending_reg == 8'hCA || pending_reg == 8'hCD) begin
        id_valid_next     = 1'b1;
        device_type_next  = (pending_reg == 8'hCD);
        device_known_next = 1'b1;
      end else begin
        err_next = 1'b1;
      end
    end

    if (err_next && err_count_reg != 8'hFF) err_count_next = err_count_reg + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg        <= EMPTY;
      pending_reg      <= '0;
      xlow_reg         <= '0;
      count_reg        <= '0;
      x_reg            <= '0;
      y_reg            <= '0;
      b1_reg           <= 1'b0;
      b2_reg           <= 1'b0;
      packet_valid_reg <= 1'b0;
      id_valid_reg     <= 1'b0;
      err_reg          <= 1'b0;
      device_type_reg  <= 1'b0;
      device_known_reg <= 1'b0;
      cursor_x_reg     <= '0;
      cursor_y_reg     <= '0;
      err_count_reg    <= '0;
    end else begin
      state_reg        <= state_next;
      pending_reg      <= pending_next;
      xlow_reg         <= xlow_next;
      count_reg        <= count_next;
      x_reg            <= x_next;
      y_reg            <= y_next;
      b1_reg           <= b1_next;
      b2_reg           <= b2_next;
      packet_valid_reg <= packet_valid_next;
      id_valid_reg     <= id_valid_next;
      err_reg          <= err_next;
      device_type_reg  <= device_type_next;
      device_known_reg <= device_known_next;
      cursor_x_reg     <= cursor_x_next;
      cursor_y_reg     <= cursor_y_next;
      err_count_reg    <= err_count_next;
    end
  end

  assign packet_valid = packet_valid_reg;
  assign x            = x_reg;
  assign y            = y_reg;
  assign b1           = b1_reg;
  assign b2           = b2_reg;
  assign id_valid     = id_valid_reg;
  assign device_type  = device_type_reg;
  assign device_known = device_known_reg;
  assign cursor_x     = cursor_x_reg;
  assign cursor_y     = cursor_y_reg;
  assign err          = err_reg;
  assign err_count    = err_count_reg;

endmodule

// File: tb/tb_pointing_device_decoder.sv
// Directed bench for pointing_device_decoder with hand-computed expectations.
// A short timeout keeps the idle waits small.
module tb_pointing_device_decoder;
  localparam int kT = 20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rts = 1'b0;
  logic [7:0] serial_in_data = 8'h00;
  logic       serial_in_write = 1'b0;
  logic       packet_valid, b1, b2, id_valid, device_type, device_known, err;
  logic [7:0] x, y, err_count;
  logic [9:0] cursor_x, cursor_y;

  int tests_run = 0;
  int tests_failed = 0;
  int n;

  pointing_device_decoder #(.kTimeoutCycles(kT), .kMaxX(767), .kMaxY(559)) dut (
    .clk(clk), .reset_n(reset_n), .rts(rts),
    .serial_in_data(serial_in_data), .serial_in_write(serial_in_write),
    .packet_valid(packet_valid), .x(x), .y(y), .b1(b1), .b2(b2),
    .id_valid(id_valid), .device_type(device_type), .device_known(device_known),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One-cycle write; returns 1 time unit after the sampling edge, when its result is visible.
  task automatic send(input logic [7:0] b);
    serial_in_data  = b;
    serial_in_write = 1'b1;
    @(posedge clk); #1;
    serial_in_write = 1'b0;
    $display("[TB] write %02h -> pv=%0d id=%0d err=%0d x=%02h y=%02h cur=(%0d,%0d) ec=%0d",
             b, packet_valid, id_valid, err, x, y, cursor_x, cursor_y, err_count);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  task automatic wait_pulse(input bit want_err, output int cycles);
    cycles = -1;
    for (int i = 1; i <= 4 * kT; i++) begin
      @(posedge clk); #1;
      if (want_err ? err : id_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    idle(2);
    check("rst_pv", packet_valid, 0);
    check("rst_id", id_valid, 0);
    check("rst_err", err, 0);
    check("rst_ec", err_count, 0);
    check("rst_cx", cursor_x, 0);
    check("rst_known", device_known, 0);
    check("rst_x", x, 0);
    reset_n = 1'b1;
    idle(1);

    // ID 0xCD then packet b1=1, x=+5, y=-3
    send(8'hCD);
    check("cd_pending_id", id_valid, 0);
    send(8'hEC);
    check("id_valid", id_valid, 1);
    check("id_type", device_type, 1);
    check("id_known", device_known, 1);
    send(8'h85);
    check("x_body_pv", packet_valid, 0);
    send(8'hBD);
    check("pkt_pv", packet_valid, 1);
    check("pkt_b1", b1, 1);
    check("pkt_b2", b2, 0);
    check("pkt_x", x, 8'h05);
    check("pkt_y", y, 8'hFD);
    check("pkt_cx", cursor_x, 5);
    check("pkt_cy", cursor_y, 0);
    check("pkt_ec", err_count, 0);
    idle(1);
    check("pv_one_cycle", packet_valid, 0);

    // Truncated packet: head arrives in GOT_X
    send(8'hEC);
    send(8'h85);
    send(8'hCD);
    check("trunc_err", err, 1);
    check("trunc_ec", err_count, 1);
    check("trunc_pv", packet_valid, 0);
    send(8'hCA);
    check("pending_cd_id", id_valid, 1);
    check("pending_cd_type", device_type, 1);
    check("pending_cd_err", err, 0);

    // Pending 0xCA left to time out
    wait_pulse(1'b0, n);
    check("id_timeout_cycles", n, kT);
    check("id_timeout_type", device_type, 0);
    check("id_timeout_known", device_known, 1);

    // Timeout in GOT_X
    send(8'hEC);
    send(8'h85);
    wait_pulse(1'b1, n);
    check("gotx_timeout_cycles", n, kT);
    check("gotx_timeout_ec", err_count, 2);

    // Write lands on the expiry cycle and wins
    send(8'hEC);
    idle(kT - 1);
    send(8'h85);
    check("race_id", id_valid, 0);
    check("race_err", err, 0);
    send(8'h81);
    check("race_pv", packet_valid, 1);
    check("race_y", y, 8'hC1);
    check("race_cx", cursor_x, 10);
    check("race_cy", cursor_y, 0);

    // Move to (2,0) with x=-8, then x=-5 y=+127 five times
    send(8'hC3); send(8'hB8); send(8'h80);
    check("move_cx", cursor_x, 2);
    check("move_cy", cursor_y, 0);
    for (int k = 0; k < 5; k++) begin
      send(8'hC7); send(8'hBB); send(8'hBF);
      if (k == 0) begin
        check("clamp0_cx", cursor_x, 0);
        check("clamp0_cy", cursor_y, 127);
      end
    end
    check("clamp_cx", cursor_x, 0);
    check("clamp_cy", cursor_y, 559);
    check("clamp_x", x, 8'hFB);
    check("clamp_y", y, 8'h7F);

    // rts between head and body; a write during rts is ignored
    send(8'hEC);
    rts = 1'b1;
    send(8'h85);
    rts = 1'b0;
    check("rts_write_err", err, 0);
    check("rts_known", device_known, 0);
    send(8'h85);
    check("stray_body_err", err, 1);
    check("stray_body_ec", err_count, 3);
    check("rts_cy_held", cursor_y, 559);

    // Non-ID pending head resolved by another head
    send(8'hEC);
    send(8'hEC);
    check("bad_id_err", err, 1);
    check("bad_id_id", id_valid, 0);
    check("bad_id_ec", err_count, 4);

    // Saturation on illegal bytes
    for (int k = 0; k < 256; k++) send(8'h00);
    check("sat_err", err, 1);
    check("sat_ec", err_count, 255);

    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    check("rst2_ec", err_count, 0);
    check("rst2_cy", cursor_y, 0);
    check("rst2_y", y, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
